// File: rtl/block_control_seq.sv
// Registered decode control unit between ID and ID/EX, with a block-transfer
// sequencer that splits LDM/STM into one single-register beat per cycle.
module block_control_seq #(
    parameter int REG_LIST_W = 16,
    parameter int IDX_W      = $clog2(REG_LIST_W),
    parameter int OFS_W      = IDX_W + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [1:0]            mode,
    input  logic [3:0]            op_code,
    input  logic                  S_in,
    input  logic [REG_LIST_W-1:0] reg_list,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  ready_in,
    output logic                  valid_out,
    output logic [3:0]            EXE_CMD,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_en,
    output logic                  S_out,
    output logic                  B,
    output logic                  illegal,
    output logic [IDX_W-1:0]      beat_reg,
    output logic [OFS_W-1:0]      beat_ofs,
    output logic                  last_beat
);

    typedef enum logic {
        IDLE,
        BLOCK
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [3:0]       exe_cmd;
        logic             mem_read;
        logic             mem_write;
        logic             wb_en;
        logic             s_out;
        logic             b;
        logic             illegal;
        logic [IDX_W-1:0] beat_reg;
        logic [OFS_W-1:0] beat_ofs;
        logic             last_beat;
    } ctrl_t;

    state_t                state_q, state_d;
    logic [REG_LIST_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  blk_load_q, blk_load_d;
    ctrl_t                 out_q, out_d;

    ctrl_t                 dec;
    logic [REG_LIST_W-1:0] src_list;
    logic [REG_LIST_W-1:0] cleared;
    logic [IDX_W-1:0]      low_idx;
    logic [IDX_W-1:0]      cnt_inc;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [REG_LIST_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Every beat of a block transfer looks like a single LDR or STR.
    function automatic ctrl_t beat_ctrl(input logic load, input logic [IDX_W-1:0] idx,
                                        input logic [OFS_W-1:0] ofs, input logic last);
        ctrl_t c;
        c           = '0;
        c.valid     = 1'b1;
        c.exe_cmd   = load ? 4'b1010 : 4'b1011;
        c.mem_read  = load;
        c.mem_write = ~load;
        c.wb_en     = load;
        c.beat_reg  = idx;
        c.beat_ofs  = ofs;
        c.last_beat = last;
        return c;
    endfunction

    // Single-op decode; anything unrecognised becomes an illegal marker.
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.last_beat = 1'b1;
        unique case (mode)
            2'b00: begin
                dec.wb_en = 1'b1;
                dec.s_out = S_in;
                unique case (op_code)
                    4'b0100: dec.exe_cmd = 4'b0000;
                    4'b0101: dec.exe_cmd = 4'b0001;
                    4'b0010: dec.exe_cmd = 4'b0011;
                    4'b0110: dec.exe_cmd = 4'b0100;
                    4'b0000: dec.exe_cmd = 4'b0101;
                    4'b1100: dec.exe_cmd = 4'b0110;
                    4'b0001: dec.exe_cmd = 4'b0111;
                    4'b1010: begin
                        dec.exe_cmd = 4'b1000;
                        dec.s_out   = 1'b1;
                        dec.wb_en   = 1'b0;
                    end
                    4'b1000: begin
                        dec.exe_cmd = 4'b1001;
                        dec.s_out   = 1'b1;
                        dec.wb_en   = 1'b0;
                    end
                    default: begin
                        dec.illegal = 1'b1;
                        dec.wb_en   = 1'b0;
                        dec.s_out   = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                if (op_code == 4'b0100) begin
                    dec.exe_cmd   = S_in ? 4'b1010 : 4'b1011;
                    dec.mem_read  = S_in;
                    dec.mem_write = ~S_in;
                    dec.wb_en     = S_in;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            2'b10: begin
                dec.b       = 1'b1;
                dec.wb_en   = 1'b1;
                dec.exe_cmd = 4'b0000;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign src_list = (state_q == BLOCK) ? rem_q : reg_list;
    assign low_idx  = lowest_idx(src_list);
    assign cleared  = src_list & ~(REG_LIST_W'(1) << low_idx);
    assign cnt_inc  = beat_cnt_q + IDX_W'(1);

    // Flush squashes everything, stall freezes everything, otherwise advance.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        beat_cnt_d = beat_cnt_q;
        blk_load_d = blk_load_q;
        out_d      = out_q;
        if (flush) begin
            out_d      = '0;
            state_d    = IDLE;
            rem_d      = '0;
            beat_cnt_d = '0;
        end else if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (!valid_in) begin
                        out_d = '0;
                    end else if (mode == 2'b11) begin
                        if (reg_list == '0) begin
                            out_d = '0;
                        end else begin
                            blk_load_d = S_in;
                            out_d      = beat_ctrl(S_in, low_idx, '0, cleared == '0);
                            rem_d      = cleared;
                            beat_cnt_d = '0;
                            if (cleared != '0) state_d = BLOCK;
                        end
                    end else begin
                        out_d = dec;
                    end
                end
                BLOCK: begin
                    out_d      = beat_ctrl(blk_load_q, low_idx, {cnt_inc, 2'b00}, cleared == '0);
                    rem_d      = cleared;
                    beat_cnt_d = cnt_inc;
                    if (cleared == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            blk_load_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            blk_load_q <= blk_load_d;
            out_q      <= out_d;
        end
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = out_q.valid;
    assign EXE_CMD   = out_q.exe_cmd;
    assign mem_read  = out_q.mem_read;
    assign mem_write = out_q.mem_write;
    assign wb_en     = out_q.wb_en;
    assign S_out     = out_q.s_out;
    assign B         = out_q.b;
    assign illegal   = out_q.illegal;
    assign beat_reg  = out_q.beat_reg;
    assign beat_ofs  = out_q.beat_ofs;
    assign last_beat = out_q.last_beat;

endmodule

// File: doc/block_control_seq.md
# block_control_seq

Registered, multi-cycle successor to the combinational decode control unit. It sits between the ID stage and the ID/EX register. It decodes mode, opcode and S into execute/memory/writeback controls, and registers them with stall and flush support. It also sequences block transfers (LDM/STM) into one single-register beat per cycle, walking a parametrised register list.

## Interface
- REG_LIST_W, 16: width of the block-transfer register list (power of 2, ≥2)
- IDX_W, $clog2(REG_LIST_W): beat register index width
- OFS_W, IDX_W+2: byte offset width (4 bytes per beat)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  decoded instruction present in ID
- mode  in  2  instruction mode field
- op_code  in  4  opcode field
- S_in  in  1  S bit; for mode 01/11 selects load (1) or store (0)
- reg_list  in  REG_LIST_W  block-transfer register list (used only for mode 11)
- stall  in  1  hazard freeze; hold state and outputs
- flush  in  1  branch-taken squash
- ready_in  out  1  sequencer can accept a new instruction (combinational, = state is IDLE)
- valid_out  out  1  output register holds a real operation
- EXE_CMD  out  4  ALU command
- mem_read, mem_write, wb_en, S_out, B  out  1 each  stage controls
- illegal  out  1  undefined mode/opcode combination
- beat_reg  out  IDX_W  register index of current block beat
- beat_ofs  out  OFS_W  byte offset of current beat (beat number × 4)
- last_beat  out  1  final beat of a block transfer (1 for all single ops)

## Operation
- Decode for mode 00, as opcode → EXE_CMD, with wb_en=1 and S_out=S_in:
  - ADD 0100→0000
  - ADC 0101→0001
  - SUB 0010→0011
  - SBC 0110→0100
  - AND 0000→0101
  - ORR 1100→0110
  - EOR 0001→0111
- CMP 1010→1000 and TST 1000→1001: S_out=1, wb_en=0. This differs from the previous unit, which wrote back.
- Mode 01, op 0100:
  - S_in=1: LDR, mem_read=1, wb_en=1, EXE_CMD=1010.
  - S_in=0: STR, mem_write=1, EXE_CMD=1011.
- Mode 10: B=1, wb_en=1, EXE_CMD=0000 (never X).
- Mode 11: block transfer, any op_code.
  - S_in=1: LDM beats, each as LDR.
  - S_in=0: STM beats, each as STR.
- Any other combination: illegal=1, valid_out=1, all other controls 0.
- States: IDLE, BLOCK. Registered `rem` (REG_LIST_W) and `beat_cnt` (IDX_W) hold the remaining list and the beat number.
- IDLE, valid_in=1 with no stall and no flush:
  - Single or illegal op: load the output register, last_beat=1, stay IDLE.
  - Mode 11 with reg_list≠0: emit beat 0 for the lowest set bit. beat_ofs=0. rem = reg_list with that bit cleared. If rem≠0, go to BLOCK with last_beat=0; else last_beat=1 and stay IDLE.
  - Mode 11 with reg_list=0: valid_out=0 (bubble), stay IDLE.
- IDLE, valid_in=0: load a bubble (valid_out=0, all controls 0).
- BLOCK, each unstalled cycle: emit the lowest set bit of rem, beat_cnt+1, beat_ofs=(beat_cnt+1)×4, clear that bit. When the cleared rem is 0, last_beat=1 and go to IDLE. Inputs are ignored in BLOCK.
- stall=1: state, rem, beat_cnt and all outputs hold. ready_in still reflects the state.
- flush=1, which overrides stall: the output register becomes a bubble, the state goes to IDLE, rem is cleared and beat_cnt is cleared.

## Timing
- Reset, asynchronous: state=IDLE, rem=0, beat_cnt=0. All outputs 0 except ready_in=1.
- Latency: decode result appears on the outputs one clk after acceptance.
- A block of N set bits produces N consecutive valid beats (absent stall). ready_in is low for the N−1 cycles after acceptance, and a new instruction is accepted on the edge emitting the last beat +1.
- Stall during BLOCK extends the sequence 1:1 with no lost or duplicated beats.
- Flush and stall together in the same cycle: flush wins.
- Full list (all REG_LIST_W bits): beat_ofs reaches (REG_LIST_W−1)×4 and never wraps.
- rst_n deasserted mid-block aborts immediately; the first post-reset cycle is IDLE.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle → all outputs 0, ready_in=1. Release, valid_in=0 → valid_out=0.
- Single ops: ADD S=1 → next cycle EXE_CMD=0000, wb_en=1, S_out=1, last_beat=1. CMP → EXE_CMD=1000, S_out=1, wb_en=0. B → B=1, wb_en=1, EXE_CMD=0000. mode 00 op 1111 → illegal=1.
- LDM reg_list=16'h8005 → 3 beats: beat_reg 0, 2, 15; beat_ofs 0, 4, 8; mem_read=1 each; last_beat only on the third. ready_in low for 2 cycles.
- STM 16'hFFFF with stall=1 for 2 cycles at beat 5 → 16 beats total. Beat 5 is held 3 cycles. beat_ofs ends at 60 and last_beat=1 only on beat 15.
- Flush at beat 1 of STM 16'h000F → next output is a bubble, ready_in=1. A following ADD is accepted normally.
- Empty list LDM 16'h0000 → valid_out=0, ready_in stays 1.
